// File: rtl/dr_pkg.sv
// Shared definitions for the DR data register.
//   dr_op_e   : the single operation executed in a cycle
//   dr_decode : priority decode of the control strobes into one dr_op_e
// RST is not decoded here; it is applied directly at the register so it
// overrides every operation.
package dr_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_CLR  = 3'd1,
    OP_LD   = 3'd2,
    OP_INC  = 3'd3,
    OP_DEC  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6
  } dr_op_e;

  // Priority: clear, load, (inc and dec together = hold), inc, dec,
  // shift left, shift right, hold.
  function automatic dr_op_e dr_decode(
    input logic clr,
    input logic ld,
    input logic inr,
    input logic dcr,
    input logic shl,
    input logic shr
  );
    dr_op_e op;
    op = OP_HOLD;
    if (clr) begin
      op = OP_CLR;
    end else if (ld) begin
      op = OP_LD;
    end else if (inr && dcr) begin
      op = OP_HOLD;
    end else if (inr) begin
      op = OP_INC;
    end else if (dcr) begin
      op = OP_DEC;
    end else if (shl) begin
      op = OP_SHL;
    end else if (shr) begin
      op = OP_SHR;
    end
    return op;
  endfunction

endpackage

// File: rtl/dr_addsub.sv
// Increment / decrement unit for the DR data register.
// Ports:
//   din     : current register value
//   dec     : 1 = decrement, 0 = increment
//   dout    : value the register takes if this operation is selected
//   cy      : carry out (increment) or borrow (decrement)
//   ovf_evt : a wrap (SAT=0) or saturation (SAT=1) event happened
// The arithmetic is done at WIDTH+1 bits; bit WIDTH is the carry/borrow,
// which is also exactly the condition for a wrap or saturation.
module dr_addsub #(
  parameter int WIDTH = 16,
  parameter int SAT   = 0
) (
  input  logic [WIDTH-1:0] din,
  input  logic             dec,
  output logic [WIDTH-1:0] dout,
  output logic             cy,
  output logic             ovf_evt
);

  logic [WIDTH:0] res;
  logic [WIDTH:0] one;

  assign one = {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    if (dec) begin
      res = {1'b0, din} - one;
    end else begin
      res = {1'b0, din} + one;
    end
  end

  assign cy      = res[WIDTH];
  assign ovf_evt = res[WIDTH];

  generate
    if (SAT != 0) begin : g_sat
      // At the boundary the register keeps its value instead of wrapping.
      assign dout = res[WIDTH] ? din : res[WIDTH-1:0];
    end else begin : g_wrap
      assign dout = res[WIDTH-1:0];
    end
  endgenerate

endmodule

// File: rtl/dr_reg_n.sv
// DR_REG_N: parameterised data register with clear, load, increment,
// decrement and serial shifts, plus zero, carry and sticky overflow flags.
// Ports:
//   CLK, RST            : clock, synchronous active-high reset
//   drCLR, drLD         : clear to RESET_VAL, parallel load of inDR
//   drINR, drDCR        : increment / decrement (both high = hold)
//   drSHL, drSHR, drSIN : shift left / right, serial fill bit
//   inDR                : parallel load data
//   DR                  : register contents
//   drZ                 : combinational DR == 0
//   drCY                : carry/borrow/shifted-out bit of the last operation
//   drOVF               : sticky wrap/saturation flag
module dr_reg_n
  import dr_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               SAT       = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             drCLR,
  input  logic             drLD,
  input  logic             drINR,
  input  logic             drDCR,
  input  logic             drSHL,
  input  logic             drSHR,
  input  logic             drSIN,
  input  logic [WIDTH-1:0] inDR,
  output logic [WIDTH-1:0] DR,
  output logic             drZ,
  output logic             drCY,
  output logic             drOVF
);

  dr_op_e           op;
  logic [WIDTH-1:0] dr_reg, dr_next;
  logic             cy_reg, cy_next;
  logic             ovf_reg, ovf_next;

  logic [WIDTH-1:0] as_out;
  logic             as_cy;
  logic             as_ovf;

  always_comb op = dr_decode(drCLR, drLD, drINR, drDCR, drSHL, drSHR);

  dr_addsub #(
    .WIDTH (WIDTH),
    .SAT   (SAT)
  ) u_addsub (
    .din     (dr_reg),
    .dec     (op == OP_DEC),
    .dout    (as_out),
    .cy      (as_cy),
    .ovf_evt (as_ovf)
  );

  always_comb begin
    dr_next  = dr_reg;
    cy_next  = cy_reg;
    ovf_next = ovf_reg;
    case (op)
      OP_CLR: begin
        dr_next  = RESET_VAL;
        cy_next  = 1'b0;
        ovf_next = 1'b0;
      end
      OP_LD: begin
        dr_next = inDR;
        cy_next = 1'b0;
      end
      OP_INC, OP_DEC: begin
        dr_next  = as_out;
        cy_next  = as_cy;
        ovf_next = ovf_reg | as_ovf;
      end
      OP_SHL: begin
        dr_next = {dr_reg[WIDTH-2:0], drSIN};
        cy_next = dr_reg[WIDTH-1];
      end
      OP_SHR: begin
        dr_next = {drSIN, dr_reg[WIDTH-1:1]};
        cy_next = dr_reg[0];
      end
      default: begin
        dr_next  = dr_reg;
        cy_next  = cy_reg;
        ovf_next = ovf_reg;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dr_reg  <= RESET_VAL;
      cy_reg  <= 1'b0;
      ovf_reg <= 1'b0;
    end else begin
      dr_reg  <= dr_next;
      cy_reg  <= cy_next;
      ovf_reg <= ovf_next;
    end
  end

  assign DR    = dr_reg;
  assign drZ   = (dr_reg == '0);
  assign drCY  = cy_reg;
  assign drOVF = ovf_reg;

endmodule

// File: tb/tb_dr_reg_n.sv
// Bench for dr_reg_n. Three instances share one stimulus stream:
//   a : WIDTH=16, SAT=0, RESET_VAL=00A5
//   b : WIDTH=16, SAT=1, RESET_VAL=0
//   c : WIDTH=4,  SAT=0, RESET_VAL=0
// A behavioural model tracks each instance and is compared every cycle;
// directed sequences add literal expectations.
module tb_dr_reg_n;

  logic        CLK;
  logic        rst, clr, ld, inr, dcr, shl, shr, sin;
  logic [15:0] din;

  logic [15:0] dr_a, dr_b;
  logic [3:0]  dr_c;
  logic        z_a, z_b, z_c, cy_a, cy_b, cy_c, ovf_a, ovf_b, ovf_c;

  int total = 0;
  int bad   = 0;
  bit check_en = 0;

  typedef struct {
    longint unsigned dr;
    bit              cy;
    bit              ovf;
  } st_t;

  st_t             m [3];
  int              mw [3] = '{16, 16, 4};
  bit              ms [3] = '{1'b0, 1'b1, 1'b0};
  longint unsigned mr [3] = '{64'h00A5, 64'h0, 64'h0};

  dr_reg_n #(.WIDTH(16), .SAT(0), .RESET_VAL(16'h00A5)) u_a (
    .CLK(CLK), .RST(rst), .drCLR(clr), .drLD(ld), .drINR(inr), .drDCR(dcr),
    .drSHL(shl), .drSHR(shr), .drSIN(sin), .inDR(din),
    .DR(dr_a), .drZ(z_a), .drCY(cy_a), .drOVF(ovf_a)
  );

  dr_reg_n #(.WIDTH(16), .SAT(1), .RESET_VAL(16'h0000)) u_b (
    .CLK(CLK), .RST(rst), .drCLR(clr), .drLD(ld), .drINR(inr), .drDCR(dcr),
    .drSHL(shl), .drSHR(shr), .drSIN(sin), .inDR(din),
    .DR(dr_b), .drZ(z_b), .drCY(cy_b), .drOVF(ovf_b)
  );

  dr_reg_n #(.WIDTH(4), .SAT(0), .RESET_VAL(4'h0)) u_c (
    .CLK(CLK), .RST(rst), .drCLR(clr), .drLD(ld), .drINR(inr), .drDCR(dcr),
    .drSHL(shl), .drSHR(shr), .drSIN(sin), .inDR(din[3:0]),
    .DR(dr_c), .drZ(z_c), .drCY(cy_c), .drOVF(ovf_c)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Next state from the operation rules, as plain arithmetic on integers.
  function automatic st_t nxt(st_t c, int w, bit sat, longint unsigned rv);
    st_t n;
    longint unsigned mask;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    n = c;
    if (rst || clr) begin
      n.dr = rv & mask; n.cy = 1'b0; n.ovf = 1'b0;
    end else if (ld) begin
      n.dr = longint'(din) & mask; n.cy = 1'b0;
    end else if (inr && dcr) begin
      n = c;
    end else if (inr) begin
      if (c.dr == mask) begin
        n.dr = sat ? c.dr : 64'd0; n.cy = 1'b1; n.ovf = 1'b1;
      end else begin
        n.dr = c.dr + 64'd1; n.cy = 1'b0;
      end
    end else if (dcr) begin
      if (c.dr == 64'd0) begin
        n.dr = sat ? 64'd0 : mask; n.cy = 1'b1; n.ovf = 1'b1;
      end else begin
        n.dr = c.dr - 64'd1; n.cy = 1'b0;
      end
    end else if (shl) begin
      n.cy = bit'((c.dr >> (w - 1)) & 64'd1);
      n.dr = ((c.dr << 1) | longint'(sin)) & mask;
    end else if (shr) begin
      n.cy = bit'(c.dr & 64'd1);
      n.dr = (c.dr >> 1) | (longint'(sin) << (w - 1));
    end
    return n;
  endfunction

  always @(posedge CLK) begin
    for (int k = 0; k < 3; k++) begin
      m[k] <= nxt(m[k], mw[k], ms[k], mr[k]);
    end
  end

  task automatic chk(string nm, longint unsigned act, longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge CLK) begin
    if (check_en) begin
      chk("a_dr",  longint'(dr_a), m[0].dr);
      chk("a_z",   longint'(z_a),  longint'(m[0].dr == 0));
      chk("a_cy",  longint'(cy_a), longint'(m[0].cy));
      chk("a_ovf", longint'(ovf_a), longint'(m[0].ovf));
      chk("b_dr",  longint'(dr_b), m[1].dr);
      chk("b_z",   longint'(z_b),  longint'(m[1].dr == 0));
      chk("b_cy",  longint'(cy_b), longint'(m[1].cy));
      chk("b_ovf", longint'(ovf_b), longint'(m[1].ovf));
      chk("c_dr",  longint'(dr_c), m[2].dr);
      chk("c_z",   longint'(z_c),  longint'(m[2].dr == 0));
      chk("c_cy",  longint'(cy_c), longint'(m[2].cy));
      chk("c_ovf", longint'(ovf_c), longint'(m[2].ovf));
    end
  end

  // Drive one cycle of controls, return at the following falling edge.
  task automatic tick(bit r, bit c, bit l, bit i, bit d, bit sl, bit sr,
                      bit s, logic [15:0] v);
    rst = r; clr = c; ld = l; inr = i; dcr = d; shl = sl; shr = sr;
    sin = s; din = v;
    @(negedge CLK);
    $display("op rst=%0b clr=%0b ld=%0b inr=%0b dcr=%0b shl=%0b shr=%0b sin=%0b din=%h -> a=%h b=%h c=%h",
             r, c, l, i, d, sl, sr, s, v, dr_a, dr_b, dr_c);
  endtask

  initial begin
    logic [15:0] v;
    rst = 0; clr = 0; ld = 0; inr = 0; dcr = 0; shl = 0; shr = 0;
    sin = 0; din = '0;
    @(negedge CLK);

    // Reset state
    tick(1, 0, 0, 0, 0, 0, 0, 0, 16'h0);
    check_en = 1;
    chk("rst_a_dr", longint'(dr_a), 64'h00A5);
    chk("rst_a_cy", longint'(cy_a), 64'h0);
    chk("rst_a_ovf", longint'(ovf_a), 64'h0);
    chk("rst_b_z", longint'(z_b), 64'h1);

    // Wrapping increment through all-ones
    tick(0, 0, 1, 0, 0, 0, 0, 0, 16'hFFFE);
    tick(0, 0, 0, 1, 0, 0, 0, 0, 16'h0);
    chk("inc1_dr", longint'(dr_a), 64'hFFFF);
    chk("inc1_cy", longint'(cy_a), 64'h0);
    tick(0, 0, 0, 1, 0, 0, 0, 0, 16'h0);
    chk("inc2_dr", longint'(dr_a), 64'h0000);
    chk("inc2_cy", longint'(cy_a), 64'h1);
    chk("inc2_ovf", longint'(ovf_a), 64'h1);
    chk("inc2_z", longint'(z_a), 64'h1);

    // Saturating decrement at zero
    tick(0, 1, 0, 0, 0, 0, 0, 0, 16'h0);
    tick(0, 0, 1, 0, 0, 0, 0, 0, 16'h0001);
    tick(0, 0, 0, 0, 1, 0, 0, 0, 16'h0);
    chk("dec1_dr", longint'(dr_b), 64'h0);
    chk("dec1_cy", longint'(cy_b), 64'h0);
    chk("dec1_ovf", longint'(ovf_b), 64'h0);
    tick(0, 0, 0, 0, 1, 0, 0, 0, 16'h0);
    chk("dec2_dr", longint'(dr_b), 64'h0);
    chk("dec2_cy", longint'(cy_b), 64'h1);
    tick(0, 0, 0, 0, 1, 0, 0, 0, 16'h0);
    chk("dec3_dr", longint'(dr_b), 64'h0);
    chk("dec3_cy", longint'(cy_b), 64'h1);
    chk("dec3_ovf", longint'(ovf_b), 64'h1);

    // Priority: load beats increment; inc+dec holds
    tick(0, 0, 1, 1, 0, 0, 0, 0, 16'h1234);
    chk("ldinc_dr", longint'(dr_a), 64'h1234);
    tick(0, 0, 0, 1, 1, 0, 0, 0, 16'h0);
    chk("incdec_dr", longint'(dr_a), 64'h1234);

    // Shifts
    tick(0, 0, 1, 0, 0, 0, 0, 0, 16'h8001);
    tick(0, 0, 0, 0, 0, 1, 0, 0, 16'h0);
    chk("shl_dr", longint'(dr_a), 64'h0002);
    chk("shl_cy", longint'(cy_a), 64'h1);
    tick(0, 0, 0, 0, 0, 0, 1, 1, 16'h0);
    chk("shr_dr", longint'(dr_a), 64'h8001);
    chk("shr_cy", longint'(cy_a), 64'h0);

    // Reset in the middle of an increment burst, together with a load
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 0, 0, 0, 0, 16'h0);
    tick(1, 0, 1, 1, 0, 0, 0, 0, 16'h5555);
    chk("rstld_dr", longint'(dr_a), 64'h00A5);
    chk("rstld_cy", longint'(cy_a), 64'h0);
    chk("rstld_ovf", longint'(ovf_a), 64'h0);
    tick(0, 0, 0, 1, 0, 0, 0, 0, 16'h0);
    chk("resume_dr", longint'(dr_a), 64'h00A6);

    // Clear
    tick(0, 1, 0, 0, 0, 0, 0, 0, 16'h0);
    chk("clr_dr", longint'(dr_a), 64'h00A5);

    // 4-bit counter wraps after 16 increments
    tick(1, 0, 0, 0, 0, 0, 0, 0, 16'h0);
    for (int i = 1; i <= 16; i++) begin
      tick(0, 0, 0, 1, 0, 0, 0, 0, 16'h0);
      chk("w4_dr", longint'(dr_c), longint'(i % 16));
      chk("w4_ovf", longint'(ovf_c), longint'(i == 16));
    end

    // Randomised traffic, loads biased toward the boundaries
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 4))
        0: v = 16'h0000;
        1: v = 16'hFFFF;
        2: v = 16'h000F;
        3: v = 16'hFFFE;
        default: v = 16'($urandom);
      endcase
      tick(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 5) == 0), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dr_reg_n.md
DR_REG_N -- requirements
Module: dr_reg_n

Interface
REQ-001 Parameter WIDTH, default 16: data register width in bits, legal range 2..64.
REQ-002 Parameter SAT, default 0: 0 means increment/decrement wrap; 1 means they saturate at all-ones/zero.
REQ-003 Parameter RESET_VAL, default 0: value loaded into DR by RST and by drCLR.
REQ-004 CLK  input  1  single clock; all state changes on its rising edge.
REQ-005 RST  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-006 drCLR  input  1  synchronous clear request.
REQ-007 drLD  input  1  parallel load of inDR.
REQ-008 drINR  input  1  increment by one.
REQ-009 drDCR  input  1  decrement by one.
REQ-010 drSHL  input  1  shift left; LSB filled from drSIN.
REQ-011 drSHR  input  1  shift right; MSB filled from drSIN.
REQ-012 drSIN  input  1  serial fill bit for shifts.
REQ-013 inDR  input  WIDTH  parallel load data.
REQ-014 DR  output  WIDTH  registered register contents.
REQ-015 drZ  output  1  combinational, high when DR equals zero.
REQ-016 drCY  output  1  registered carry out of the last increment, borrow of the last decrement, or bit shifted out.
REQ-017 drOVF  output  1  registered sticky flag: a wrap or saturation event occurred.

Function
REQ-018 Exactly one operation SHALL execute per cycle, in this priority order: RST, drCLR, drLD, (drINR and drDCR both high = hold), drINR, drDCR, drSHL, drSHR, hold.
REQ-019 drCLR SHALL set DR to RESET_VAL, clear drCY and clear drOVF in the next cycle.
REQ-020 drLD SHALL set DR to inDR one cycle later, clear drCY, and leave drOVF unchanged.
REQ-021 drINR SHALL compute the sum at WIDTH+1 bits; with SAT=0, DR takes the low WIDTH bits and drCY takes the carry.
REQ-022 drDCR SHALL compute the difference at WIDTH+1 bits; with SAT=0, DR takes the low WIDTH bits and drCY takes the borrow.
REQ-023 With SAT=1, increment at all-ones and decrement at zero SHALL leave DR unchanged and set drCY.
REQ-024 Any wrap (SAT=0) or saturation (SAT=1) SHALL set drOVF; drOVF stays set until RST or drCLR.
REQ-025 drSHL SHALL set DR to {DR[WIDTH-2:0], drSIN} with drCY = old DR[WIDTH-1].
REQ-026 drSHR SHALL set DR to {drSIN, DR[WIDTH-1:1]} with drCY = old DR[0].
REQ-027 Hold, including simultaneous drINR and drDCR, SHALL keep DR, drCY and drOVF unchanged.
REQ-028 Update latency SHALL be one cycle for every operation; drZ SHALL reflect DR in the same cycle with no added latency.

Reset
REQ-029 On RST high at a rising edge: DR = RESET_VAL, drCY = 0, drOVF = 0, overriding every other control input.
REQ-030 RST asserted during an ongoing count or shift sequence SHALL discard that sequence; operation resumes from RESET_VAL on the first cycle after RST falls.
REQ-031 No asynchronous reset path SHALL exist; the initial-block register preset is not used.

Structure
REQ-032 Shared package dr_pkg SHALL hold the operation enum (OP_HOLD, OP_CLR, OP_LD, OP_INC, OP_DEC, OP_SHL, OP_SHR) and the priority-decode function.
REQ-033 Sub-module dr_addsub SHALL implement the WIDTH-parameterised increment/decrement with carry/borrow and saturation detection.
REQ-034 The top level SHALL contain only operation decode, the DR/flag registers and drZ.

Verification (WIDTH=16 unless stated)
REQ-035 SAT=0: load 16'hFFFE, then 2x drINR -> DR = FFFF (drCY=0), then DR = 0000, drCY=1, drOVF=1, drZ=1.
REQ-036 SAT=1: load 16'h0001, then 3x drDCR -> DR = 0000, 0000, 0000; drCY=1 from the second cycle on; drOVF=1.
REQ-037 drLD and drINR together with inDR=16'h1234 -> DR = 1234; drINR and drDCR together -> DR unchanged.
REQ-038 Load 16'h8001, drSHL with drSIN=0 -> DR = 0002, drCY=1; then drSHR with drSIN=1 -> DR = 8001, drCY=0.
REQ-039 RST asserted during a drINR burst, RESET_VAL=16'h00A5 -> DR = 00A5 and flags 0 the next cycle, and RST beats a simultaneous drLD.
REQ-040 WIDTH=4, SAT=0: 16x drINR from 0 -> DR returns to 0 and drOVF is set exactly at the wrap.
